dcache_stb_responder: RTL and testbench

Data-cache-side responder for the store buffer write port. Accepts one byte-masked write request at a time from the store buffer, commits it to a word-addressed data array after a programmable latency, and returns a single-cycle acknowledge. Also serves LSU word reads from the same array, holding each read off until the store buffer has drained so that loads observe every earlier store. Sits between the store buffer and the data memory, in place of the full dcache for integration and bring-up.

---
 rtl/dcache_stb_responder.sv | 101 ++++++++++
 tb/tb_dcache_stb_responder.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_stb_responder.sv
// dcache_stb_responder: store-buffer write responder and LSU read port over a word-addressed data array
module dcache_stb_responder #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = 4,
   parameter int MEM_DEPTH      = 256,
   parameter int WR_LATENCY     = 2,
   parameter int RD_LATENCY     = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
   input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
   input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
   input  logic                      stb2dcache_w_en,
   input  logic                      stb2dcache_req,
   input  logic                      dmem_sel_i,
   input  logic                      stb2dcache_empty,
   output logic                      dcache2stb_ack,
   input  logic [ADDR_WIDTH-1:0]     lsu2dcache_addr,
   input  logic                      lsu2dcache_req,
   output logic [DATA_WIDTH-1:0]     dcache2lsu_rdata,
   output logic                      dcache2lsu_ack,
   output logic                      dcache_busy
);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
   localparam int CNT_W = $clog2(MAX_LAT) + 1;
   localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LATENCY - 1);
   localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, WR_WAIT, WR_ACK, RD_WAIT, RD_ACK} state_t;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic [IDX_W-1:0]          idx_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [BYTE_SEL_WIDTH-1:0] sel_q;
   logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
   logic                      wr_valid, rd_valid, idle, commit, capture;
   logic                      unused_addr;

   // loads wait for a drained store buffer so they observe every earlier store
   assign wr_valid = stb2dcache_req && stb2dcache_w_en && dmem_sel_i;
   assign rd_valid = lsu2dcache_req && stb2dcache_empty && !stb2dcache_req;
   assign idle     = state == IDLE;
   assign commit   = state == WR_WAIT && cnt == '0;
   assign capture  = state == RD_WAIT && cnt == '0;

   assign unused_addr = ^{stb2dcache_addr[ADDR_WIDTH-1:IDX_W+2], stb2dcache_addr[1:0],
                          lsu2dcache_addr[ADDR_WIDTH-1:IDX_W+2], lsu2dcache_addr[1:0]};

   assign dcache2stb_ack = state == WR_ACK;
   assign dcache2lsu_ack = state == RD_ACK;
   assign dcache_busy    = !idle;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            state_nxt = wr_valid ? WR_WAIT : rd_valid ? RD_WAIT : IDLE;
            cnt_nxt   = wr_valid ? WR_CNT : rd_valid ? RD_CNT : cnt;
         end
         WR_WAIT, RD_WAIT: begin
            state_nxt = (cnt != '0) ? state : (state == WR_WAIT) ? WR_ACK : RD_ACK;
            cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= '0;
         idx_q            <= '0;
         wdata_q          <= '0;
         sel_q            <= '0;
         dcache2lsu_rdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (idle && (wr_valid || rd_valid))
            idx_q <= wr_valid ? stb2dcache_addr[IDX_W+1:2] : lsu2dcache_addr[IDX_W+1:2];
         if (idle && wr_valid) begin
            wdata_q <= stb2dcache_wdata;
            sel_q   <= stb2dcache_sel_byte;
         end
         if (capture)
            dcache2lsu_rdata <= mem[idx_q];
      end
   end

   // array is deliberately unreset; a reset before the commit edge blocks the write via state
   always_ff @(posedge clk) begin
      if (commit)
         for (int i = 0; i < BYTE_SEL_WIDTH; i++)
            if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
   end
endmodule

// File: tb/tb_dcache_stb_responder.sv
// tb_dcache_stb_responder: scoreboard bench for the store-buffer responder (WR_LATENCY=2, RD_LATENCY=1)
module tb_dcache_stb_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] stb2dcache_addr = '0;
   logic [31:0] stb2dcache_wdata = '0;
   logic [3:0]  stb2dcache_sel_byte = '0;
   logic        stb2dcache_w_en = 1'b0;
   logic        stb2dcache_req = 1'b0;
   logic        dmem_sel_i = 1'b0;
   logic        stb2dcache_empty = 1'b1;
   logic        dcache2stb_ack;
   logic [31:0] lsu2dcache_addr = '0;
   logic        lsu2dcache_req = 1'b0;
   logic [31:0] dcache2lsu_rdata;
   logic        dcache2lsu_ack;
   logic        dcache_busy;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model [256];
   logic [31:0] exp_q [$];

   dcache_stb_responder dut (
      .clk(clk), .rst_n(rst_n),
      .stb2dcache_addr(stb2dcache_addr), .stb2dcache_wdata(stb2dcache_wdata),
      .stb2dcache_sel_byte(stb2dcache_sel_byte), .stb2dcache_w_en(stb2dcache_w_en),
      .stb2dcache_req(stb2dcache_req), .dmem_sel_i(dmem_sel_i),
      .stb2dcache_empty(stb2dcache_empty), .dcache2stb_ack(dcache2stb_ack),
      .lsu2dcache_addr(lsu2dcache_addr), .lsu2dcache_req(lsu2dcache_req),
      .dcache2lsu_rdata(dcache2lsu_rdata), .dcache2lsu_ack(dcache2lsu_ack),
      .dcache_busy(dcache_busy)
   );

   always #5 clk = ~clk;

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++)
         if (s[i]) model[a[9:2]][8*i +: 8] = d[8*i +: 8];
   endfunction

   // called at a negedge; bit k of the masks is the value sampled in cycle k (cycle 0 = request)
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [7:0] ack_m, output logic [7:0] busy_m);
      int done = -1;
      ack_m = '0;
      busy_m = '0;
      ack_m[0] = dcache2stb_ack;
      busy_m[0] = dcache_busy;
      stb2dcache_addr = a;
      stb2dcache_wdata = d;
      stb2dcache_sel_byte = s;
      stb2dcache_w_en = 1'b1;
      dmem_sel_i = 1'b1;
      stb2dcache_req = 1'b1;
      model_write(a, d, s);
      for (int k = 1; k < 40; k++) begin
         @(negedge clk);
         if (k < 8) begin
            ack_m[k] = dcache2stb_ack;
            busy_m[k] = dcache_busy;
         end
         if (done < 0 && dcache2stb_ack) begin
            done = k;
            stb2dcache_req = 1'b0;
         end
         if (done >= 0 && k == done + 1) break;
      end
      stb2dcache_req = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [7:0] ack_m, output logic [31:0] rd);
      int done = -1;
      ack_m = '0;
      rd = 'x;
      ack_m[0] = dcache2lsu_ack;
      lsu2dcache_addr = a;
      lsu2dcache_req = 1'b1;
      for (int k = 1; k < 40; k++) begin
         @(negedge clk);
         if (k < 8) ack_m[k] = dcache2lsu_ack;
         if (done < 0 && dcache2lsu_ack) begin
            done = k;
            rd = dcache2lsu_rdata;
            lsu2dcache_req = 1'b0;
         end
         if (done >= 0 && k == done + 1) break;
      end
      lsu2dcache_req = 1'b0;
   endtask

   task automatic test_reset();
      stb2dcache_req = 1'b1;
      stb2dcache_w_en = 1'b1;
      dmem_sel_i = 1'b1;
      stb2dcache_sel_byte = 4'hF;
      lsu2dcache_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vectors++;
         if ({dcache2stb_ack, dcache2lsu_ack, dcache_busy} !== 3'b000 || dcache2lsu_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hold: ack/lack/busy=%b rdata=%h, want 000 / 00000000",
                     {dcache2stb_ack, dcache2lsu_ack, dcache_busy}, dcache2lsu_rdata);
         end
      end
      stb2dcache_req = 1'b0;
      stb2dcache_w_en = 1'b0;
      dmem_sel_i = 1'b0;
      lsu2dcache_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({dcache2stb_ack, dcache2lsu_ack, dcache_busy} !== 3'b000 || dcache2lsu_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_idle: ack/lack/busy=%b rdata=%h, want 000 / 00000000",
                  {dcache2stb_ack, dcache2lsu_ack, dcache_busy}, dcache2lsu_rdata);
      end
   endtask

   task automatic test_write_read();
      logic [7:0] am, bm;
      logic [31:0] rd, exp;
      do_write(32'h10, 32'hDEADBEEF, 4'hF, am, bm);
      vectors++;
      if (am !== 8'b0000_1000) begin
         miscompares++;
         $display("FAIL wr_ack_timing: got %b want 00001000", am);
      end
      vectors++;
      if (bm !== 8'b0000_1110) begin
         miscompares++;
         $display("FAIL wr_busy_timing: got %b want 00001110", bm);
      end
      exp_q.push_back(model[8'h04]);
      do_read(32'h10, am, rd);
      exp = exp_q.pop_front();
      vectors++;
      if (am !== 8'b0000_0100) begin
         miscompares++;
         $display("FAIL rd_ack_timing: got %b want 00000100", am);
      end
      vectors++;
      if (rd !== exp) begin
         miscompares++;
         $display("FAIL rd_0x10: got %h want %h", rd, exp);
      end
   endtask

   task automatic test_byte_merge();
      logic [7:0] am, bm;
      logic [31:0] rd, exp;
      do_write(32'h30, 32'h11223344, 4'hF, am, bm);
      do_write(32'h30, 32'hAABBCCDD, 4'b0101, am, bm);
      vectors++;
      if (am !== 8'b0000_1000) begin
         miscompares++;
         $display("FAIL merge_ack: got %b want 00001000", am);
      end
      exp_q.push_back(32'h11BB33DD);
      do_read(32'h30, am, rd);
      exp = exp_q.pop_front();
      vectors++;
      if (rd !== exp) begin
         miscompares++;
         $display("FAIL byte_merge: got %h want %h", rd, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] am, bm;
      logic [31:0] rd, exp, a;
      for (int i = 0; i < 4; i++) begin
         do_write(32'h50 + 32'(4 * i), $urandom, 4'hF, am, bm);
         vectors++;
         if (am !== 8'b0000_1000) begin
            miscompares++;
            $display("FAIL b2b_full_ack[%0d]: got %b want 00001000", i, am);
         end
      end
      for (int i = 0; i < 8; i++) begin
         do_write(32'h50 + 32'(4 * $urandom_range(0, 3)), $urandom, 4'($urandom), am, bm);
         vectors++;
         if (am !== 8'b0000_1000) begin
            miscompares++;
            $display("FAIL b2b_part_ack[%0d]: got %b want 00001000", i, am);
         end
      end
      for (int i = 0; i < 4; i++) begin
         a = 32'h50 + 32'(4 * i);
         exp_q.push_back(model[a[9:2]]);
         do_read(a, am, rd);
         exp = exp_q.pop_front();
         vectors++;
         if (rd !== exp) begin
            miscompares++;
            $display("FAIL b2b_read[%0d]: got %h want %h", i, rd, exp);
         end
      end
   endtask

   task automatic test_priority();
      int stb_k = -1, lsu_k = -1;
      logic [31:0] rd = '0, exp;
      stb2dcache_empty = 1'b1;
      stb2dcache_addr = 32'h60;
      stb2dcache_wdata = 32'h12345678;
      stb2dcache_sel_byte = 4'hF;
      stb2dcache_w_en = 1'b1;
      dmem_sel_i = 1'b1;
      stb2dcache_req = 1'b1;
      lsu2dcache_addr = 32'h60;
      lsu2dcache_req = 1'b1;
      model_write(32'h60, 32'h12345678, 4'hF);
      exp_q.push_back(model[8'h18]);
      for (int k = 1; k < 30; k++) begin
         @(negedge clk);
         if (stb_k < 0 && dcache2stb_ack) begin
            stb_k = k;
            stb2dcache_req = 1'b0;
         end
         if (lsu_k < 0 && dcache2lsu_ack) begin
            lsu_k = k;
            rd = dcache2lsu_rdata;
            lsu2dcache_req = 1'b0;
            break;
         end
      end
      stb2dcache_req = 1'b0;
      lsu2dcache_req = 1'b0;
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (stb_k != 3 || lsu_k != 6) begin
         miscompares++;
         $display("FAIL prio_timing: wr ack cycle %0d rd ack cycle %0d, want 3 and 6", stb_k, lsu_k);
      end
      vectors++;
      if (rd !== exp) begin
         miscompares++;
         $display("FAIL prio_data: got %h want %h", rd, exp);
      end
   endtask

   task automatic test_ordering();
      int stb_k = -1, lsu_k = -1, early = 0;
      logic [31:0] rd = '0, exp;
      stb2dcache_empty = 1'b0;
      stb2dcache_addr = 32'h20;
      stb2dcache_wdata = 32'h5A5A5A5A;
      stb2dcache_sel_byte = 4'hF;
      stb2dcache_w_en = 1'b1;
      dmem_sel_i = 1'b1;
      stb2dcache_req = 1'b1;
      lsu2dcache_addr = 32'h20;
      lsu2dcache_req = 1'b1;
      model_write(32'h20, 32'h5A5A5A5A, 4'hF);
      exp_q.push_back(model[8'h08]);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (dcache2lsu_ack) early++;
         if (stb_k < 0 && dcache2stb_ack) begin
            stb_k = k;
            stb2dcache_req = 1'b0;
         end
      end
      vectors++;
      if (stb_k != 3) begin
         miscompares++;
         $display("FAIL order_wr_ack: cycle %0d want 3", stb_k);
      end
      vectors++;
      if (early != 0) begin
         miscompares++;
         $display("FAIL order_early_rd: %0d lsu acks while not empty, want 0", early);
      end
      stb2dcache_empty = 1'b1;
      for (int k = 1; k < 20; k++) begin
         @(negedge clk);
         if (dcache2lsu_ack) begin
            lsu_k = k;
            rd = dcache2lsu_rdata;
            lsu2dcache_req = 1'b0;
            break;
         end
      end
      lsu2dcache_req = 1'b0;
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (lsu_k != 2) begin
         miscompares++;
         $display("FAIL order_rd_ack: cycle %0d want 2", lsu_k);
      end
      vectors++;
      if (rd !== exp) begin
         miscompares++;
         $display("FAIL order_data: got %h want %h", rd, exp);
      end
   endtask

   task automatic test_ignored();
      logic [7:0] am;
      logic [31:0] rd, exp;
      int bad = 0;
      stb2dcache_addr = 32'h10;
      stb2dcache_wdata = 32'h0;
      stb2dcache_sel_byte = 4'hF;
      stb2dcache_req = 1'b1;
      stb2dcache_w_en = 1'b1;
      dmem_sel_i = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (k == 10) begin
            stb2dcache_w_en = 1'b0;
            dmem_sel_i = 1'b1;
         end
         @(negedge clk);
         if (dcache2stb_ack || dcache_busy) bad++;
      end
      stb2dcache_req = 1'b0;
      stb2dcache_w_en = 1'b0;
      dmem_sel_i = 1'b0;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL ignored_req: %0d cycles with ack/busy, want 0", bad);
      end
      exp_q.push_back(model[8'h04]);
      do_read(32'h10, am, rd);
      exp = exp_q.pop_front();
      vectors++;
      if (rd !== exp) begin
         miscompares++;
         $display("FAIL ignored_unchanged: got %h want %h", rd, exp);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] am, bm;
      logic [31:0] rd, exp;
      int bad = 0;
      do_write(32'h40, 32'h0, 4'hF, am, bm);
      stb2dcache_addr = 32'h40;
      stb2dcache_wdata = 32'hFFFFFFFF;
      stb2dcache_sel_byte = 4'hF;
      stb2dcache_w_en = 1'b1;
      dmem_sel_i = 1'b1;
      stb2dcache_req = 1'b1;
      @(negedge clk);
      vectors++;
      if (dcache_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre_busy: got %b want 1", dcache_busy);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (dcache_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_async_busy: got %b want 0", dcache_busy);
      end
      stb2dcache_req = 1'b0;
      stb2dcache_w_en = 1'b0;
      dmem_sel_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (dcache2stb_ack || dcache2lsu_ack) bad++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (dcache2stb_ack || dcache2lsu_ack) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL rst_no_ack: %0d ack cycles, want 0", bad);
      end
      exp_q.push_back(model[8'h10]);
      do_read(32'h40, am, rd);
      exp = exp_q.pop_front();
      vectors++;
      if (rd !== exp) begin
         miscompares++;
         $display("FAIL rst_aborted_write: got %h want %h", rd, exp);
      end
      do_write(32'h400, 32'hCAFEF00D, 4'hF, am, bm);
      exp_q.push_back(model[8'h00]);
      do_read(32'h0, am, rd);
      exp = exp_q.pop_front();
      vectors++;
      if (rd !== exp) begin
         miscompares++;
         $display("FAIL alias_0x400: got %h want %h", rd, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_byte_merge();
      test_back_to_back();
      test_priority();
      test_ordering();
      test_ignored();
      test_reset_mid_write();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
